axonerve_kvs_resp_collector: RTL
================================

// Module: axonerve_kvs_resp_collector
// PURPOSE
//  Downstream stage of the Axonerve KVS kernel. Captures each kernel result (ACK pulse + hit flags + key/value) into
//  a tagged response word, buffers it in an on-chip FWFT ring FIFO, and presents it on a valid/ready stream to the host.
//  Exports almost-full so upstream command issue can throttle, plus drop/response counters and a sticky overflow flag.
// PARAMETERS
//  DEPTH        32  FIFO entries; power of 2, >=4
//  AFULL_MARGIN 4   O_RESP_AFULL asserts when count >= DEPTH-AFULL_MARGIN
//  SEQ_W        16  width of per-response sequence tag
// PORTS
//  I_CLK          in   1       clock
//  I_XRST         in   1       reset, synchronous, active-low
//  I_KERNEL_READY in   1       kernel O_READY
//  I_ACK          in   1       kernel O_ACK (1-cycle pulse per completed command)
//  I_ENT_ERR      in   1       kernel O_ENT_ERR, valid with I_ACK
//  I_SINGLE_HIT   in   1       kernel O_SINGLE_HIT, valid with I_ACK
//  I_MULTI_HIT    in   1       kernel O_MULTI_HIT, valid with I_ACK
//  I_KEY_DAT      in   128     kernel O_KEY_DAT, valid with I_ACK
//  I_KEY_PRI      in   7       kernel O_KEY_PRI, valid with I_ACK
//  I_KEY_VALUE    in   32      kernel O_KEY_VALUE, valid with I_ACK
//  I_CLR_STATUS   in   1       pulse: clear counters, overflow flag, sequence tag
//  I_FLUSH        in   1       pulse: discard all buffered responses
//  O_RESP_VALID   out  1       head-of-FIFO valid
//  I_RESP_READY   in   1       consumer accepts head when VALID&&READY
//  O_RESP_DATA    out  RESP_W  head response word (layout below)
//  O_RESP_AFULL   out  1       almost-full (registered)
//  O_RESP_COUNT   out  32      responses accepted into FIFO, saturating
//  O_DROP_COUNT   out  32      ACKs dropped on full, saturating
//  O_OVERFLOW     out  1       sticky: at least one drop since reset/clear
//  O_STATE        out  2      FSM state, debug
// BEHAVIOUR
//  - Reset (I_XRST=0 at posedge): FIFO empty, seq=0, counters=0, O_OVERFLOW=0, O_RESP_VALID=0, O_RESP_AFULL=0,
//    O_RESP_DATA=0, state=ST_WAIT_READY. Reset mid-stream discards all buffered words.
//  - Word layout: [127:0] key, [159:128] value, [166:160] pri, [167] shit, [168] mhit, [169] ent_err,
//    [170+SEQ_W-1:170] seq. RESP_W = 170+SEQ_W (186 default); +32 with timestamp option.
//  - FSM: ST_WAIT_READY(0): ACKs ignored, not counted; -> ST_RUN when I_KERNEL_READY=1.
//    ST_RUN(1): ACK captured; -> ST_WAIT_READY when I_KERNEL_READY=0 (kernel re-init). Buffered words stay poppable.
//    Encoding 2,3 unused -> ST_WAIT_READY.
//  - Capture: I_ACK=1 in ST_RUN at cycle N -> word written at edge N; O_RESP_VALID=1 in cycle N+1 if FIFO was empty.
//  - Push accepted if count<DEPTH, or count==DEPTH with pop in the same cycle. Accepted push: seq++ (wraps modulo
//    2^SEQ_W), O_RESP_COUNT++. Rejected push: word lost, seq unchanged, O_DROP_COUNT++, O_OVERFLOW<=1.
//  - Pop: VALID&&READY at edge advances head. Simultaneous push+pop leaves count unchanged. Pop on empty: no-op.
//  - O_RESP_DATA stable while VALID&&!READY. Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  - I_FLUSH: at the edge, FIFO empty, a coincident push is dropped without counting, a coincident pop is ignored.
//    seq and counters are unchanged.
//  - I_CLR_STATUS: at the edge, counters=0, O_OVERFLOW=0, seq=0. A coincident push is counted after clear
//    (RESP_COUNT=1, tag 0). A coincident drop is also counted after clear (DROP_COUNT=1, OVERFLOW=1).
//  - Counters saturate at 32'hFFFF_FFFF. O_RESP_AFULL is updated from the next-cycle count.
// CONFIGURATION
//  AXONERVE_KVS_RESP_TIMESTAMP_EN defined: a free-running 32-bit cycle counter (0 at reset, wraps) is sampled
//  at capture into bits [RESP_W-1:RESP_W-32].
//  Undefined: no counter, RESP_W=170+SEQ_W.
// STRUCTURE
//  - Package axonerve_kvs_pkg: resp_flags_t struct {ent_err,mhit,shit}, resp_word_t packed struct, field offset localparams,
//    RESP_W (ifdef-dependent), FSM enum rc_state_t {ST_WAIT_READY, ST_RUN}.
//  - Sub-module axonerve_kvs_resp_fifo: generic FWFT register ring FIFO, params WIDTH/DEPTH, ports push/pop/flush/count.
//    The collector holds the FSM, tagging, counters and drop logic.
// TESTING
//  1 Reset, READY=1, 3 ACKs (shit=1, value 0x11,0x22,0x33), READY held 1 -> 3 words, seq 0,1,2, shit=1, RESP_COUNT=3.
//  2 READY=0, 5 ACKs -> FIFO empty, RESP_COUNT=0, O_STATE=0; READY=1 then 1 ACK -> word with seq 0.
//  3 DEPTH=32, READY_out=0, 35 ACKs -> count 32, DROP_COUNT=3, OVERFLOW=1, AFULL=1 from 28th push; pop all -> seq 0..31 in order.
//  4 FIFO full, ACK and pop in the same cycle -> push accepted, DROP_COUNT unchanged, count stays 32.
//  5 10 buffered words, I_FLUSH and ACK in the same cycle -> VALID=0 next cycle, RESP_COUNT unchanged, next ACK seq=10.
//  6 SEQ_W=4, 17 ACKs with continuous pop -> 17th word has seq 0. With TIMESTAMP_EN, ACKs at cycles 100/105 -> stamps differ by 5.

Source files
------------

// File: rtl/axonerve_kvs_pkg.sv
// Shared types and field layout for the Axonerve KVS response collector.
// AXONERVE_KVS_RESP_TIMESTAMP_EN appends a 32-bit capture timestamp at the top of each word.
package axonerve_kvs_pkg;

  localparam int unsigned KEY_W     = 128;
  localparam int unsigned VAL_W     = 32;
  localparam int unsigned PRI_W     = 7;
  localparam int unsigned BASE_W    = 170;
  localparam int unsigned SEQ_W_DEF = 16;
`ifdef AXONERVE_KVS_RESP_TIMESTAMP_EN
  localparam int unsigned TS_W      = 32;
`else
  localparam int unsigned TS_W      = 0;
`endif
  localparam int unsigned RESP_W    = BASE_W + SEQ_W_DEF + TS_W;

  typedef struct packed {
    logic ent_err;
    logic mhit;
    logic shit;
  } resp_flags_t;

  typedef struct packed {
`ifdef AXONERVE_KVS_RESP_TIMESTAMP_EN
    logic [31:0]          ts;
`endif
    logic [SEQ_W_DEF-1:0] seq;
    resp_flags_t          flags;
    logic [PRI_W-1:0]     pri;
    logic [VAL_W-1:0]     value;
    logic [KEY_W-1:0]     key;
  } resp_word_t;

  typedef enum logic [1:0] {
    ST_WAIT_READY = 2'd0,
    ST_RUN        = 2'd1
  } rc_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axonerve_kvs_resp_fifo.sv
// First-word-fall-through register ring FIFO with registered head word and valid.
module axonerve_kvs_resp_fifo #(
  parameter int unsigned WIDTH = 186,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       valid,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_next
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_q, wr_q, rd_n, wr_n;
  logic [CW-1:0]    count_q, count_n;
  logic [WIDTH-1:0] head_n;
  logic             do_pop, do_push;

  always_comb begin
    do_pop  = pop && (count_q != '0) && !flush;
    do_push = push && !flush && ((count_q < CW'(DEPTH)) || do_pop);
    rd_n    = flush ? '0 : (do_pop  ? rd_q + AW'(1) : rd_q);
    wr_n    = flush ? '0 : (do_push ? wr_q + AW'(1) : wr_q);
    count_n = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    // The incoming word becomes the head directly when it lands in the head slot.
    head_n  = (do_push && (wr_q == rd_n)) ? din : mem[rd_n];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      valid   <= 1'b0;
      dout    <= '0;
    end else begin
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      count_q <= count_n;
      valid   <= (count_n != '0);
      if (count_n != '0) dout <= head_n;
    end
  end

  assign count      = count_q;
  assign count_next = count_n;

endmodule

// File: rtl/axonerve_kvs_resp_collector.sv
// Collects Axonerve KVS kernel results into tagged words and streams them to the host.
// AXONERVE_KVS_RESP_TIMESTAMP_EN adds a free-running capture timestamp to each word.
module axonerve_kvs_resp_collector
  import axonerve_kvs_pkg::*;
#(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned AFULL_MARGIN = 4,
  parameter int unsigned SEQ_W        = 16
) (
  input  logic                            I_CLK,
  input  logic                            I_XRST,
  input  logic                            I_KERNEL_READY,
  input  logic                            I_ACK,
  input  logic                            I_ENT_ERR,
  input  logic                            I_SINGLE_HIT,
  input  logic                            I_MULTI_HIT,
  input  logic [KEY_W-1:0]                I_KEY_DAT,
  input  logic [PRI_W-1:0]                I_KEY_PRI,
  input  logic [VAL_W-1:0]                I_KEY_VALUE,
  input  logic                            I_CLR_STATUS,
  input  logic                            I_FLUSH,
  output logic                            O_RESP_VALID,
  input  logic                            I_RESP_READY,
  output logic [BASE_W+SEQ_W+TS_W-1:0]    O_RESP_DATA,
  output logic                            O_RESP_AFULL,
  output logic [31:0]                     O_RESP_COUNT,
  output logic [31:0]                     O_DROP_COUNT,
  output logic                            O_OVERFLOW,
  output logic [1:0]                      O_STATE
);

  localparam int unsigned W  = BASE_W + SEQ_W + TS_W;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  rc_state_t        state_q, state_n;
  logic [SEQ_W-1:0] seq_q, seq_tag_c;
  logic [CW-1:0]    count, count_next;
  logic             capture_c, pop_c, push_ok_c, drop_c;
  resp_flags_t      flags_c;
  logic [W-1:0]     word_c;

  always_ff @(posedge I_CLK) begin
    if (!I_XRST) state_q <= ST_WAIT_READY;
    else         state_q <= state_n;
  end

  // Kernel re-init drops back to waiting; buffered words remain poppable.
  always_comb begin
    state_n = ST_WAIT_READY;
    case (state_q)
      ST_WAIT_READY: state_n = I_KERNEL_READY ? ST_RUN : ST_WAIT_READY;
      ST_RUN:        state_n = I_KERNEL_READY ? ST_RUN : ST_WAIT_READY;
      default:       state_n = ST_WAIT_READY;
    endcase
  end

  assign O_STATE = state_q;

  // Flush swallows a coincident push uncounted and ignores a coincident pop.
  assign capture_c = I_ACK && (state_q == ST_RUN) && !I_FLUSH;
  assign pop_c     = O_RESP_VALID && I_RESP_READY && !I_FLUSH;
  assign push_ok_c = capture_c && ((count < CW'(DEPTH)) || pop_c);
  assign drop_c    = capture_c && !push_ok_c;
  assign seq_tag_c = I_CLR_STATUS ? '0 : seq_q;
  assign flags_c   = '{ent_err: I_ENT_ERR, mhit: I_MULTI_HIT, shit: I_SINGLE_HIT};

`ifdef AXONERVE_KVS_RESP_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge I_CLK) begin
    if (!I_XRST) ts_q <= '0;
    else         ts_q <= ts_q + 32'd1;
  end

  assign word_c = {ts_q, seq_tag_c, flags_c, I_KEY_PRI, I_KEY_VALUE, I_KEY_DAT};
`else
  assign word_c = {seq_tag_c, flags_c, I_KEY_PRI, I_KEY_VALUE, I_KEY_DAT};
`endif

  axonerve_kvs_resp_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (I_CLK),
    .rst_n      (I_XRST),
    .push       (push_ok_c),
    .din        (word_c),
    .pop        (pop_c),
    .flush      (I_FLUSH),
    .valid      (O_RESP_VALID),
    .dout       (O_RESP_DATA),
    .count      (count),
    .count_next (count_next)
  );

  // Clear takes effect first, so a coincident push or drop is counted afterwards.
  always_ff @(posedge I_CLK) begin
    if (!I_XRST) begin
      seq_q        <= '0;
      O_RESP_COUNT <= '0;
      O_DROP_COUNT <= '0;
      O_OVERFLOW   <= 1'b0;
      O_RESP_AFULL <= 1'b0;
    end else begin
      O_RESP_AFULL <= (count_next >= CW'(DEPTH - AFULL_MARGIN));
      if (I_CLR_STATUS) begin
        seq_q        <= SEQ_W'(push_ok_c);
        O_RESP_COUNT <= 32'(push_ok_c);
        O_DROP_COUNT <= 32'(drop_c);
        O_OVERFLOW   <= drop_c;
      end else begin
        if (push_ok_c) begin
          seq_q        <= seq_q + SEQ_W'(1);
          O_RESP_COUNT <= sat_inc32(O_RESP_COUNT);
        end
        if (drop_c) begin
          O_DROP_COUNT <= sat_inc32(O_DROP_COUNT);
          O_OVERFLOW   <= 1'b1;
        end
      end
    end
  end

endmodule
